// File: rtl/inner_bus_arbiter_pkg.sv
// Shared types and default sizing for the inner bus arbiter.
package inner_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_HOLD_MAX = 4;

endpackage

// File: rtl/inner_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/inner_bus_arbiter.sv
// Round-robin arbiter granting one requester at a time onto the inner bus,
// with packet-based release and a per-grant beat limit.
//
// state | meaning
// IDLE  | no owner; pick next requester from rr_ptr, outputs all zero
// OWN   | owner holds the bus until last beat or HOLD_MAX beats
module inner_bus_arbiter
  import inner_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  localparam int IW      = $clog2(NUM_REQ),
  localparam int CW      = $clog2(HOLD_MAX + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IW-1:0]               grant_id,
  output logic                        busy
);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            xfer;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    out_valid  = 1'b0;
    out_data   = '0;
    req_ready  = '0;
    grant_id   = '0;
    busy       = 1'b0;
    xfer       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = OWN;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        busy               = 1'b1;
        grant_id           = owner_q;
        out_valid          = req_valid[owner_q];
        req_ready[owner_q] = out_ready;
        if (out_valid) out_data = data_arr[owner_q];
        xfer = out_valid && out_ready;
        if (xfer) begin
          // Release on last beat or when this transfer reaches HOLD_MAX.
          if (req_last[owner_q] || (beat_cnt_q == CW'(HOLD_MAX - 1))) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_inner_bus_arbiter.sv
// Directed self-checking bench for inner_bus_arbiter at default parameters.
module tb_inner_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant_id;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  inner_bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_data", out_data, 0);
    step();
    rst_n = 1'b1;

    // Single requester, 3-beat packet
    req_valid = 4'b0100;
    set_data(2, 8'h11);
    #1;
    chk("s_idle_busy", busy, 0);
    chk("s_idle_out_valid", out_valid, 0);
    step();
    chk("s_grant_id", grant_id, 2);
    chk("s_busy", busy, 1);
    chk("s_b1_data", out_data, 8'h11);
    chk("s_b1_ready", req_ready, 4'b0100);
    step();
    set_data(2, 8'h22);
    #1;
    chk("s_b2_data", out_data, 8'h22);
    chk("s_b2_cnt", dut.beat_cnt_q, 1);
    step();
    set_data(2, 8'h33);
    req_last = 4'b0100;
    #1;
    chk("s_b3_data", out_data, 8'h33);
    chk("s_b3_valid", out_valid, 1);
    step();
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("s_rel_busy", busy, 0);
    chk("s_rel_grant", grant_id, 0);
    chk("s_rel_ptr", dut.rr_ptr_q, 3);

    // Reset pulse re-aligns rr_ptr to 0
    rst_n = 1'b0;
    #1;
    chk("rr_rst_ptr", dut.rr_ptr_q, 0);
    step();
    rst_n = 1'b1;

    // Round-robin, all valid, single-beat packets
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 8'hA0 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr_grant_%0d", k), grant_id, k % 4);
      chk($sformatf("rr_data_%0d", k), out_data, 8'hA0 + 8'(k % 4));
      step();
      chk($sformatf("rr_gap_%0d", k), busy, 0);
    end
    chk("rr_ptr_end", dut.rr_ptr_q, 1);

    // HOLD_MAX cut-off: req1 streams without last, req0/req2 single beats
    req_valid = 4'b0111;
    req_last  = 4'b0101;
    set_data(1, 8'hB1);
    set_data(0, 8'hB0);
    set_data(2, 8'hB2);
    step();
    chk("h_grant1", grant_id, 1);
    chk("h_data1", out_data, 8'hB1);
    for (int b = 1; b < 4; b++) begin
      step();
      chk($sformatf("h_hold_%0d", b), grant_id, 1);
      chk($sformatf("h_cnt_%0d", b), dut.beat_cnt_q, b);
    end
    step();
    chk("h_rel_busy", busy, 0);
    chk("h_rel_ptr", dut.rr_ptr_q, 2);
    step();
    chk("h_grant2", grant_id, 2);
    step();
    step();
    chk("h_grant0", grant_id, 0);
    step();
    step();
    chk("h_regrant1", grant_id, 1);
    req_last = 4'b0010;
    step();
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("h_end_busy", busy, 0);

    // Backpressure on req0 (ptr=2 wraps to 0)
    req_valid = 4'b0001;
    set_data(0, 8'hC0);
    step();
    chk("bp_grant0", grant_id, 0);
    step();
    set_data(0, 8'hC1);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_data_%0d", c), out_data, 8'hC1);
      chk($sformatf("bp_ready_%0d", c), req_ready, 0);
      chk($sformatf("bp_cnt_%0d", c), dut.beat_cnt_q, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_cnt_after", dut.beat_cnt_q, 2);

    // Owner valid gap while others request
    req_valid = 4'b1110;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("gap_busy_%0d", c), busy, 1);
      chk($sformatf("gap_valid_%0d", c), out_valid, 0);
      chk($sformatf("gap_data_%0d", c), out_data, 0);
      chk($sformatf("gap_grant_%0d", c), grant_id, 0);
      step();
    end
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    set_data(0, 8'hC2);
    #1;
    chk("gap_resume_data", out_data, 8'hC2);
    step();
    req_valid = '0;
    req_last  = '0;
    #1;
    chk("gap_rel_busy", busy, 0);
    chk("gap_rel_ptr", dut.rr_ptr_q, 1);

    // Reset mid-grant during beat 2 of req1
    req_valid = 4'b0010;
    set_data(1, 8'hD1);
    step();
    chk("mr_grant1", grant_id, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", req_ready, 0);
    chk("mr_data", out_data, 0);
    chk("mr_grant", grant_id, 0);
    chk("mr_ptr", dut.rr_ptr_q, 0);
    req_valid = 4'b1000;
    set_data(3, 8'hD3);
    step();
    rst_n = 1'b1;
    step();
    chk("mr_grant3", grant_id, 3);
    chk("mr_data3", out_data, 8'hD3);
    req_valid = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
